// File: rtl/audio_sample_fifo_if.sv
// Sample-stream bundle between the I2S receiver, the sample FIFO and its consumer.
// The slave modport is the FIFO's view; master is the receiver/consumer side.
interface audio_sample_fifo_if #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_channel;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_channel;
  logic [LW-1:0]        level;
  logic                 overflow;
  logic [15:0]          drop_count;
  logic                 clr_stats;

  modport slave (
    input  in_valid, in_data, in_channel, out_ready, clr_stats,
    output out_valid, out_data, out_channel, level, overflow, drop_count
  );

  modport master (
    output in_valid, in_data, in_channel, out_ready, clr_stats,
    input  out_valid, out_data, out_channel, level, overflow, drop_count
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Show-ahead FIFO for channel-tagged PCM samples from the I2S receiver.
// Samples arriving while full are dropped and counted (sticky flag + saturating count).
module audio_sample_fifo #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16
) (
  input  logic                clk,
  input  logic                rst,
  audio_sample_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_SIZE:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic empty, full, pop, push, drop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop   = !empty && bus.out_ready;
    push  = bus.in_valid && (!full || pop);
    drop  = bus.in_valid && full && !pop;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    // A clear wins over a drop in the same cycle; that drop goes uncounted.
    if (bus.clr_stats) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_channel, bus.in_data};
  end

  always_comb begin
    bus.out_valid   = !empty;
    bus.out_channel = mem_q[rd_ptr_q[AW-1:0]][DATA_SIZE];
    bus.out_data    = mem_q[rd_ptr_q[AW-1:0]][DATA_SIZE-1:0];
    bus.level       = wr_ptr_q - rd_ptr_q;
    bus.overflow    = overflow_q;
    bus.drop_count  = drop_count_q;
  end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Buffers PCM samples coming out of the I2S receiver stage so that a slower or bursty consumer (SPI readout, DMA, filter) can drain them under a valid/ready handshake. Each sample is tagged with the I2S word-select channel it was captured on. Samples that arrive while the buffer is full are counted and discarded. Sits directly downstream of the I2S receiver, on the same clock.

## Interface
- `DATA_SIZE`, 16: sample width in bits (8, 16, 24 or 32); must match the receiver.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  one-cycle strobe marking a new sample; driven by the receiver's `ready`.
- `in_data`  in  DATA_SIZE  sample; sampled only when `in_valid`=1.
- `in_channel`  in  1  I2S word-select level for this sample (0 = left, 1 = right).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head this cycle.
- `out_data`  out  DATA_SIZE  head sample.
- `out_channel`  out  1  head channel tag.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: set when a sample has been dropped.
- `drop_count`  out  16  dropped-sample count, saturating at 16'hFFFF.
- `clr_stats`  in  1  clears `overflow` and `drop_count`.

## Operation
- Storage is DEPTH × (DATA_SIZE+1) bits, holding {channel, data}.
- Write pointer and read pointer are each $clog2(DEPTH)+1 bits, with the extra MSB acting as a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Push: accepted when `in_valid` is 1 and either the FIFO is not full or a pop occurs in the same cycle. An accepted push writes the entry at the write pointer and increments the write pointer.
- Pop: occurs when `out_valid` and `out_ready` are both 1. The read pointer increments.
- Show-ahead output: `out_data` and `out_channel` always present the entry at the read pointer. Their value is undefined when `out_valid` is 0.
- `out_valid` equals not-empty.
- `level` is the write pointer minus the read pointer, modulo 2^($clog2(DEPTH)+1).
- Drop: `in_valid` is 1, the FIFO is full, and no pop occurs that cycle.
  - The sample is discarded and FIFO contents are unchanged.
  - `overflow` is set to 1.
  - `drop_count` increments unless it is already 16'hFFFF.
- `clr_stats` has priority over a drop in the same cycle: `overflow` becomes 0 and `drop_count` becomes 0. The concurrent drop is not counted.
- No reordering: the FIFO never merges or skips samples and preserves arrival order and channel tag.

## Timing
- Reset (`rst`=1 at a rising edge) sets both pointers to 0, `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0. Memory contents are not reset.
- Reset applies mid-stream: all buffered samples are lost. `in_valid` during reset is ignored.
- Latency: a sample pushed at edge N gives `out_valid`=1 with that data in the cycle after edge N. There is no combinational path from `in_*` to `out_*`.
- A pop at edge N presents the next entry, or `out_valid`=0, after edge N.
- `out_ready` may be held high while `out_valid`=0; this has no effect.
- The consumer may deassert `out_ready` at any time. The head entry is stable until popped.
- Simultaneous push and pop:
  - When empty: push only, since no pop is possible.
  - When full: both occur, `level` stays at DEPTH, and nothing is dropped.
  - Otherwise: both occur and `level` is unchanged.
- Pointer wrap: after DEPTH pushes the low bits return to 0 and the MSB toggles. Ordering and full/empty detection must stay correct across repeated wraps.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` toggling → `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0.
- **Basic order:** push 0x1111/ch0, 0x2222/ch1, 0x3333/ch0 with `out_ready`=0 → `level`=3. Then raise `out_ready` → read the same three values and tags in order, then `out_valid`=0 and `level`=0.
- **Overflow:** with DEPTH=16 and `out_ready`=0, push 20 samples 0..19 → `level`=16, `overflow`=1, `drop_count`=4. Drain → outputs 0..15. Pulse `clr_stats` → `overflow`=0, `drop_count`=0.
- **Full with simultaneous push/pop:** fill to 16, then push 0xAAAA while popping in the same cycle → `level` stays 16, `drop_count` unchanged, 0xAAAA emerges last.
- **Wrap and stream:** run 100 pushes at random cadence against a random `out_ready` pattern (≥50% high) → output sequence identical to the input sequence, `level` never exceeds 16, no drops.
- **Mid-stream reset:** with `level`=5, assert `rst` for 1 cycle → `level`=0 and `out_valid`=0. Next push 0xBEEF → that value appears alone at the head one cycle later.
